led_pattern_drive: RTL and testbench

- Multi-channel LED pattern generator, the parametrised successor to the single-blink LED driver.
- Runs on the 1 kHz divided clock; one clock cycle equals 1 ms.
- Mode, duty and direction are loaded at run time through a valid/ready config port.
- Produces OFF, ON, BLINK, CHASE, DIM (PWM) and ALT patterns with selectable active polarity, plus a per-period tick.

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_pattern_drive.sv | 158 +++++++++++++++
 tb/tb_led_pattern_drive.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: mode codes, FSM states
// and a width helper for the counters.
package led_pkg;

  localparam logic [2:0] LED_MODE_OFF   = 3'd0;
  localparam logic [2:0] LED_MODE_ON    = 3'd1;
  localparam logic [2:0] LED_MODE_BLINK = 3'd2;
  localparam logic [2:0] LED_MODE_CHASE = 3'd3;
  localparam logic [2:0] LED_MODE_DIM   = 3'd4;
  localparam logic [2:0] LED_MODE_ALT   = 3'd5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } led_state_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Modulo-P_MOD counter with synchronous clear. Exposes the next count so the
// owner can register outputs in the same edge the counter moves, and a wrap
// flag that is high while the counter sits on its last value and is enabled.
module led_tick_gen #(
  parameter int P_MOD = 10,
  parameter int P_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [P_W-1:0] cnt_nxt,
  output logic           wrap
);

  localparam logic [P_W-1:0] LAST = P_W'(P_MOD - 1);

  logic [P_W-1:0] cnt;

  assign wrap = en && !clr && (cnt == LAST);

  // Next count: clear dominates, then wrap, then increment when enabled.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)       cnt_nxt = '0;
    else if (wrap) cnt_nxt = '0;
    else if (en)   cnt_nxt = cnt + P_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/led_pattern_drive.sv
// Multi-channel LED pattern generator on the 1 kHz clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | pattern running, config port ready
// ST_LOAD | one-cycle restart: counters, phase and chase pointer re-seeded
//
// o_led is registered from the next-state values so a step becomes visible
// on the same edge that the period counter wraps, together with the tick.
module led_pattern_drive import led_pkg::*; #(
  parameter int P_LED_NUMBER = 4,
  parameter int P_PERIOD_MS  = 1000,
  parameter int P_CNT_W      = 17,
  parameter int P_PWM_STEPS  = 10,
  parameter int P_LED_ON     = 1
) (
  input  logic                    w_clk_1KHz,
  input  logic                    i_rst,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [2:0]              i_cfg_mode,
  input  logic [3:0]              i_cfg_duty,
  input  logic                    i_cfg_dir,
  output logic [P_LED_NUMBER-1:0] o_led,
  output logic                    o_phase_tick,
  output logic [2:0]              o_mode
);

  localparam int PWM_W = clog2(P_PWM_STEPS);
  localparam logic [P_LED_NUMBER-1:0] LED_IDLE = (P_LED_ON != 0) ? '0 : '1;

  function automatic logic [P_LED_NUMBER-1:0] even_mask();
    logic [P_LED_NUMBER-1:0] m;
    m = '0;
    for (int i = 0; i < P_LED_NUMBER; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [P_LED_NUMBER-1:0] ALT_EVEN = even_mask();

  led_state_t state, state_nxt;
  logic [2:0] mode_q, mode_nxt;
  logic [3:0] duty_q, duty_nxt;
  logic dir_q, dir_nxt;
  logic phase_q, phase_nxt;
  logic [P_LED_NUMBER-1:0] ptr_q, ptr_nxt;
  logic [P_LED_NUMBER-1:0] led_q, led_nxt, raw;
  logic tick_q, tick_nxt;
  logic hold_led;
  logic dim_on;

  logic [P_CNT_W-1:0] per_cnt_nxt;
  logic per_wrap;
  logic [PWM_W-1:0] pwm_cnt_nxt;
  logic pwm_wrap;
  logic unused_cnt;

  // The period counter only needs its wrap; the PWM counter only its value.
  assign unused_cnt = ^{per_cnt_nxt, pwm_wrap};

  led_tick_gen #(.P_MOD(P_PERIOD_MS), .P_W(P_CNT_W)) u_period (
    .clk     (w_clk_1KHz),
    .rst     (i_rst),
    .clr     (state == ST_LOAD),
    .en      (state == ST_RUN),
    .cnt_nxt (per_cnt_nxt),
    .wrap    (per_wrap)
  );

  led_tick_gen #(.P_MOD(P_PWM_STEPS), .P_W(PWM_W)) u_pwm (
    .clk     (w_clk_1KHz),
    .rst     (i_rst),
    .clr     (state == ST_LOAD),
    .en      (1'b1),
    .cnt_nxt (pwm_cnt_nxt),
    .wrap    (pwm_wrap)
  );

  // Next-state: config acceptance beats a coincident step; LOAD re-seeds.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    duty_nxt  = duty_q;
    dir_nxt   = dir_q;
    phase_nxt = phase_q;
    ptr_nxt   = ptr_q;
    tick_nxt  = 1'b0;
    hold_led  = 1'b0;
    case (state)
      ST_RUN: begin
        if (i_cfg_valid) begin
          state_nxt = ST_LOAD;
          mode_nxt  = (i_cfg_mode > LED_MODE_ALT) ? LED_MODE_OFF : i_cfg_mode;
          duty_nxt  = (i_cfg_duty > 4'(P_PWM_STEPS)) ? 4'(P_PWM_STEPS) : i_cfg_duty;
          dir_nxt   = i_cfg_dir;
          hold_led  = 1'b1;
        end else if (per_wrap) begin
          phase_nxt = ~phase_q;
          ptr_nxt   = dir_q ? {ptr_q[0], ptr_q[P_LED_NUMBER-1:1]}
                            : {ptr_q[P_LED_NUMBER-2:0], ptr_q[P_LED_NUMBER-1]};
          tick_nxt  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
        phase_nxt = 1'b0;
        ptr_nxt   = dir_q ? {1'b1, {(P_LED_NUMBER-1){1'b0}}} : P_LED_NUMBER'(1);
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Active-high pattern for the upcoming cycle, then polarity applied.
  always_comb begin
    dim_on = ({1'b0, duty_q} > 5'(pwm_cnt_nxt));
    raw    = '0;
    case (mode_q)
      LED_MODE_ON:    raw = '1;
      LED_MODE_BLINK: raw = {P_LED_NUMBER{phase_nxt}};
      LED_MODE_CHASE: raw = ptr_nxt;
      LED_MODE_DIM:   raw = {P_LED_NUMBER{dim_on}};
      LED_MODE_ALT:   raw = phase_nxt ? ~ALT_EVEN : ALT_EVEN;
      default:        raw = '0;
    endcase
    if (hold_led)           led_nxt = led_q;
    else if (P_LED_ON != 0) led_nxt = raw;
    else                    led_nxt = ~raw;
  end

  // State and output registers.
  always_ff @(posedge w_clk_1KHz or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_RUN;
      mode_q  <= LED_MODE_OFF;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      ptr_q   <= '0;
      led_q   <= LED_IDLE;
      tick_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      duty_q  <= duty_nxt;
      dir_q   <= dir_nxt;
      phase_q <= phase_nxt;
      ptr_q   <= ptr_nxt;
      led_q   <= led_nxt;
      tick_q  <= tick_nxt;
    end
  end

  assign o_cfg_ready  = (state == ST_RUN);
  assign o_led        = led_q;
  assign o_phase_tick = tick_q;
  assign o_mode       = mode_q;

endmodule

// File: tb/tb_led_pattern_drive.sv
// Bench for led_pattern_drive: two instances (active-high and active-low
// LEDs) share one stimulus stream and are checked every cycle against a
// model that derives the pattern from the time elapsed since the last load.
module tb_led_pattern_drive;

  localparam int N   = 4;
  localparam int PER = 4;
  localparam int PWM = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [2:0]   mode_in;
  logic [3:0]   duty_in;
  logic         dir_in;
  logic         ready_hi, ready_lo, tick_hi, tick_lo;
  logic [N-1:0] led_hi, led_lo;
  logic [2:0]   mode_hi, mode_lo;

  always #5 clk = ~clk;

  led_pattern_drive #(.P_LED_NUMBER(N), .P_PERIOD_MS(PER), .P_CNT_W(3),
                      .P_PWM_STEPS(PWM), .P_LED_ON(1)) dut_hi (
    .w_clk_1KHz(clk), .i_rst(rst), .i_cfg_valid(valid), .o_cfg_ready(ready_hi),
    .i_cfg_mode(mode_in), .i_cfg_duty(duty_in), .i_cfg_dir(dir_in),
    .o_led(led_hi), .o_phase_tick(tick_hi), .o_mode(mode_hi));

  led_pattern_drive #(.P_LED_NUMBER(N), .P_PERIOD_MS(PER), .P_CNT_W(3),
                      .P_PWM_STEPS(PWM), .P_LED_ON(0)) dut_lo (
    .w_clk_1KHz(clk), .i_rst(rst), .i_cfg_valid(valid), .o_cfg_ready(ready_lo),
    .i_cfg_mode(mode_in), .i_cfg_duty(duty_in), .i_cfg_dir(dir_in),
    .o_led(led_lo), .o_phase_tick(tick_lo), .o_mode(mode_lo));

  int n_checks = 0;
  int n_fail   = 0;
  string sec = "reset";

  // Reference model: settings of the running pattern and cycles since load.
  int           m_mode, m_duty, m_t;
  bit           m_dir, m_pending, m_tick;
  logic [N-1:0] m_raw;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s @%0t: got %0h, expected %0h", sec, tag, $time, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pattern(input int md, input int du, input bit dr, input int t);
    int step, idx;
    logic [N-1:0] r;
    step = t / PER;
    r = '0;
    case (md)
      1: r = '1;
      2: r = (step % 2 == 1) ? '1 : '0;
      3: begin
        idx = step % N;
        if (dr) idx = N - 1 - idx;
        r[idx] = 1'b1;
      end
      4: r = ((t % PWM) < du) ? '1 : '0;
      5: for (int i = 0; i < N; i++) r[i] = ((i + step) % 2 == 0);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_duty = 0; m_dir = 0; m_t = 0;
    m_pending = 0; m_tick = 0; m_raw = '0;
  endtask

  task automatic model_edge();
    if (m_pending) begin
      m_pending = 0;
      m_t = 0;
      m_raw = pattern(m_mode, m_duty, m_dir, 0);
      m_tick = 0;
    end else if (valid) begin
      m_mode = (mode_in > 3'd5) ? 0 : int'(mode_in);
      m_duty = int'(duty_in);
      m_dir = dir_in;
      m_pending = 1;
      m_tick = 0;
    end else begin
      m_t++;
      m_raw = pattern(m_mode, m_duty, m_dir, m_t);
      m_tick = (m_t % PER == 0);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_lo;
    exp_lo = ~m_raw;
    check_val("led_hi",   led_hi,   m_raw);
    check_val("led_lo",   led_lo,   exp_lo);
    check_val("tick_hi",  tick_hi,  m_tick);
    check_val("tick_lo",  tick_lo,  m_tick);
    check_val("ready_hi", ready_hi, !m_pending);
    check_val("ready_lo", ready_lo, !m_pending);
    check_val("mode_hi",  mode_hi,  m_mode);
    check_val("mode_lo",  mode_lo,  m_mode);
  endtask

  task automatic cycle(input bit v, input int md, input int du, input bit dr);
    valid = v; mode_in = 3'(md); duty_in = 4'(du); dir_in = dr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mode_in = '0; duty_in = '0; dir_in = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    sec = "blink";
    cycle(1, 2, 0, 0);
    idle(14);

    sec = "chase_up";
    cycle(1, 3, 0, 0);
    idle(20);
    sec = "chase_dn";
    cycle(1, 3, 0, 1);
    idle(20);

    sec = "dim3";
    cycle(1, 4, 3, 0);
    idle(25);
    sec = "dim0";
    cycle(1, 4, 0, 0);
    idle(12);
    sec = "dim15";
    cycle(1, 4, 15, 0);
    idle(12);

    sec = "alt_on_wrap";
    cycle(1, 2, 0, 0);
    for (int i = 0; i < 10 && (m_pending || (m_t % PER) != PER - 1); i++) idle(1);
    check_val("wrap_aligned", m_t % PER, PER - 1);
    cycle(1, 5, 0, 0);
    idle(12);

    sec = "held_valid";
    cycle(1, 1, 0, 0);
    cycle(1, 3, 0, 1);
    cycle(1, 3, 0, 1);
    idle(12);

    sec = "on";
    cycle(1, 1, 0, 0);
    idle(4);
    sec = "reserved";
    cycle(1, 7, 9, 1);
    idle(6);
    sec = "restart_same";
    cycle(1, 3, 0, 0);
    idle(6);
    cycle(1, 3, 0, 0);
    idle(6);

    sec = "reset_mid_chase";
    cycle(1, 3, 0, 0);
    idle(6);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    idle(8);

    sec = "random";
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
